clock_output: RTL and testbench
===============================

Name: clock_output

Overview:
- Display-formatting stage of the alarm clock.
- Takes the binary hour/minute/second time count and registers it out as per-digit BCD for the seven-segment driver.
- Two outputs: a compact HH:MM pair (c_*) for the alarm/compare path, and a full HH:MM:SS set (H_/M_/S_*) for the main display.
- Sits between the timekeeping counter and the display multiplexer.

Parameters:
- none (field limits fixed: hour 0-23, minute 0-59, second 0-59)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all outputs
- tmp_hour  input  6  binary hour, legal 0-23
- tmp_minute  input  6  binary minute, legal 0-59
- tmp_second  input  6  binary second, legal 0-59
- c_hour1  output  2  compact-display hour tens digit (0-2)
- c_hour0  output  4  compact-display hour units digit (0-9)
- c_min1  output  4  compact-display minute tens digit (0-5)
- c_min0  output  4  compact-display minute units digit (0-9)
- H_out1  output  2  hour tens digit
- H_out0  output  4  hour units digit
- M_out1  output  4  minute tens digit
- M_out0  output  4  minute units digit
- S_out1  output  4  second tens digit
- S_out0  output  4  second units digit

Behaviour:
- Clocking and reset:
  - Single clock domain; every output is a flop.
  - reset sampled high on a rising edge: all ten outputs go to 0 on that edge (display 00:00:00).
  - reset has priority over input capture.
  - While reset is held, outputs stay 0.
- Latency:
  - Inputs are sampled on each rising edge with reset low.
  - Digits for those inputs appear after that edge: 1-cycle latency.
  - Outputs then remain stable until the next edge.
  - Inputs may change every cycle; no handshake.
- Range handling (per field, independently, before conversion):
  - tmp_hour > 23 is saturated to 23.
  - tmp_minute > 59 is saturated to 59.
  - tmp_second > 59 is saturated to 59.
  - A legal field is never altered by an illegal neighbour.
- Conversion:
  - Tens digit = value / 10; units digit = value mod 10, both unsigned.
  - Implement with a compare/subtract chain or a lookup; no divider IP.
  - Hour tens occupies 2 bits (max 2); minute and second tens use 4 bits with upper bit always 0 (max 5).
  - Units digits range 0-9 only; codes 10-15 never appear on any output.
- Compact outputs:
  - c_hour1/c_hour0/c_min1/c_min0 always equal H_out1/H_out0/M_out1/M_out0 on the same cycle.
  - They are a separate register copy, not wired aliases, so they can fan out independently.
- Boundaries:
  - 23:59:59 -> 00:00:00 wrap is driven entirely by the inputs; this block holds no counting state.
  - Reset asserted mid-stream: the next edge forces 0.
  - The first edge after reset deassertion outputs the then-current inputs.
- Unknown/X inputs are not sanitised; the bench drives known values only.

Test Plan:
- Hold reset high 2 cycles with inputs 10/20/30 -> all outputs 0; release reset -> next edge H_out1=1 H_out0=0 M_out1=2 M_out0=0 S_out1=3 S_out0=0, c_hour1=1 c_hour0=0 c_min1=2 c_min0=0.
- Inputs 0/0/0 then 23/59/59 on consecutive cycles -> outputs 00:00:00 then 2,3:5,9:5,9 exactly one cycle after each input; c_* match H/M.
- Out-of-range 40/63/60 -> outputs 23:59:59; mixed 24/7/61 -> 23:07:59 (minute unaffected).
- Exhaustive sweep hour 0-23, minute 0-59, second 0-59 -> tens*10+units equals the input every cycle; no units digit >9; hour tens never >2.
- Inputs changing every cycle (09:09:09, 19:19:19, 20:00:01) -> each value appears exactly one cycle later, no skipped or repeated samples.
- Assert reset while showing 12:34:56 -> next edge all zero; deassert with input 05:06:07 -> 0,5:0,6:0,7 on following edge.

Source files
------------

// File: rtl/clock_output_if.sv
// Time-to-display bus: binary h/m/s in from the counter, registered BCD digits out.
// The master drives the binary time count; the slave returns per-digit BCD.
interface clock_output_if;
  logic [5:0] tmp_hour;
  logic [5:0] tmp_minute;
  logic [5:0] tmp_second;
  logic [1:0] c_hour1;
  logic [3:0] c_hour0;
  logic [3:0] c_min1;
  logic [3:0] c_min0;
  logic [1:0] H_out1;
  logic [3:0] H_out0;
  logic [3:0] M_out1;
  logic [3:0] M_out0;
  logic [3:0] S_out1;
  logic [3:0] S_out0;

  modport master (
    output tmp_hour, tmp_minute, tmp_second,
    input  c_hour1, c_hour0, c_min1, c_min0,
    input  H_out1, H_out0, M_out1, M_out0, S_out1, S_out0
  );

  modport slave (
    input  tmp_hour, tmp_minute, tmp_second,
    output c_hour1, c_hour0, c_min1, c_min0,
    output H_out1, H_out0, M_out1, M_out0, S_out1, S_out0
  );
endinterface

// File: rtl/clock_output.sv
// Alarm-clock display formatter: saturates each binary time field and registers it
// out as BCD tens/units digits, with an independent register copy for the HH:MM compare path.
module clock_output (
  input  logic          clk,
  input  logic          reset,
  clock_output_if.slave bus
);

  function automatic logic [5:0] sat_field(input logic [5:0] v, input logic [5:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Units are taken mod 16 from v[3:0]; subtracting (tens*10 mod 16) gives the exact
  // 0-9 remainder because the true result always fits in four bits.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [3:0] k;
    if (v >= 6'd50) begin
      t = 4'd5; k = 4'd2;
    end else if (v >= 6'd40) begin
      t = 4'd4; k = 4'd8;
    end else if (v >= 6'd30) begin
      t = 4'd3; k = 4'd14;
    end else if (v >= 6'd20) begin
      t = 4'd2; k = 4'd4;
    end else if (v >= 6'd10) begin
      t = 4'd1; k = 4'd10;
    end else begin
      t = 4'd0; k = 4'd0;
    end
    return {t, v[3:0] - k};
  endfunction

  function automatic logic [5:0] hour_to_bcd(input logic [5:0] v);
    logic [1:0] t;
    logic [3:0] k;
    if (v >= 6'd20) begin
      t = 2'd2; k = 4'd4;
    end else if (v >= 6'd10) begin
      t = 2'd1; k = 4'd10;
    end else begin
      t = 2'd0; k = 4'd0;
    end
    return {t, v[3:0] - k};
  endfunction

  logic [1:0] h1_d, h1_q, ch1_q;
  logic [3:0] h0_d, h0_q, ch0_q;
  logic [3:0] m1_d, m1_q, cm1_q;
  logic [3:0] m0_d, m0_q, cm0_q;
  logic [3:0] s1_d, s1_q;
  logic [3:0] s0_d, s0_q;

  always_comb begin
    {h1_d, h0_d} = hour_to_bcd(sat_field(bus.tmp_hour, 6'd23));
    {m1_d, m0_d} = to_bcd(sat_field(bus.tmp_minute, 6'd59));
    {s1_d, s0_d} = to_bcd(sat_field(bus.tmp_second, 6'd59));
  end

  // Output register stage: main display set plus a separate compact copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      h1_q  <= '0;
      h0_q  <= '0;
      m1_q  <= '0;
      m0_q  <= '0;
      s1_q  <= '0;
      s0_q  <= '0;
      ch1_q <= '0;
      ch0_q <= '0;
      cm1_q <= '0;
      cm0_q <= '0;
    end else begin
      h1_q  <= h1_d;
      h0_q  <= h0_d;
      m1_q  <= m1_d;
      m0_q  <= m0_d;
      s1_q  <= s1_d;
      s0_q  <= s0_d;
      ch1_q <= h1_d;
      ch0_q <= h0_d;
      cm1_q <= m1_d;
      cm0_q <= m0_d;
    end
  end

  assign bus.H_out1  = h1_q;
  assign bus.H_out0  = h0_q;
  assign bus.M_out1  = m1_q;
  assign bus.M_out0  = m0_q;
  assign bus.S_out1  = s1_q;
  assign bus.S_out0  = s0_q;
  assign bus.c_hour1 = ch1_q;
  assign bus.c_hour0 = ch0_q;
  assign bus.c_min1  = cm1_q;
  assign bus.c_min0  = cm0_q;

endmodule

// File: tb/tb_clock_output.sv
// Bench for clock_output: reset/latency vectors from a table, hand sequences for
// reset corner cases, then sweeps and random traffic against a divide/modulo model.
module tb_clock_output;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  clock_output_if bus ();

  clock_output dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic [35:0] exp;
  } vec_t;

  function automatic logic [35:0] pack(int ht, int hu, int mt, int mu, int st, int su);
    logic [1:0] a; logic [3:0] b, c, d, e, f;
    a = ht[1:0]; b = hu[3:0]; c = mt[3:0]; d = mu[3:0]; e = st[3:0]; f = su[3:0];
    return {a, b, c, d, a, b, c, d, e, f};
  endfunction

  function automatic logic [35:0] model(int h, int m, int s);
    int hs, ms, ss;
    hs = (h > 23) ? 23 : h;
    ms = (m > 59) ? 59 : m;
    ss = (s > 59) ? 59 : s;
    return pack(hs / 10, hs % 10, ms / 10, ms % 10, ss / 10, ss % 10);
  endfunction

  function automatic logic [35:0] actual();
    return {bus.c_hour1, bus.c_hour0, bus.c_min1, bus.c_min0,
            bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0, bus.S_out1, bus.S_out0};
  endfunction

  task automatic drive(input int h, input int m, input int s);
    bus.tmp_hour   = 6'(h);
    bus.tmp_minute = 6'(m);
    bus.tmp_second = 6'(s);
  endtask

  task automatic check(input string name, input logic [35:0] exp);
    logic [35:0] act;
    act = actual();
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step_check(input string name, input int h, input int m, input int s,
                            input logic [35:0] exp);
    drive(h, m, s);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{h: 6'd0,  m: 6'd0,  s: 6'd0,  exp: pack(0, 0, 0, 0, 0, 0)};
    tbl[1] = '{h: 6'd23, m: 6'd59, s: 6'd59, exp: pack(2, 3, 5, 9, 5, 9)};
    tbl[2] = '{h: 6'd40, m: 6'd63, s: 6'd60, exp: pack(2, 3, 5, 9, 5, 9)};
    tbl[3] = '{h: 6'd24, m: 6'd7,  s: 6'd61, exp: pack(2, 3, 0, 7, 5, 9)};
    tbl[4] = '{h: 6'd9,  m: 6'd9,  s: 6'd9,  exp: pack(0, 9, 0, 9, 0, 9)};
    tbl[5] = '{h: 6'd19, m: 6'd19, s: 6'd19, exp: pack(1, 9, 1, 9, 1, 9)};
    tbl[6] = '{h: 6'd20, m: 6'd0,  s: 6'd1,  exp: pack(2, 0, 0, 0, 0, 1)};
    tbl[7] = '{h: 6'd0,  m: 6'd0,  s: 6'd0,  exp: pack(0, 0, 0, 0, 0, 0)};
    tbl[8] = '{h: 6'd12, m: 6'd34, s: 6'd56, exp: pack(1, 2, 3, 4, 5, 6)};

    // Reset held two cycles with live inputs.
    reset = 1'b1;
    drive(10, 20, 30);
    @(posedge clk); #1; check("reset_hold_1", '0);
    @(posedge clk); #1; check("reset_hold_2", '0);
    reset = 1'b0;
    step_check("reset_release", 10, 20, 30, pack(1, 0, 2, 0, 3, 0));

    // Table vectors applied back to back, one new input every cycle.
    for (int i = 0; i < 9; i++)
      step_check($sformatf("table_%0d", i), tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].exp);

    // Reset while showing 12:34:56, then release onto 05:06:07.
    reset = 1'b1;
    @(posedge clk); #1; check("midstream_reset", '0);
    reset = 1'b0;
    step_check("post_reset_first", 5, 6, 7, pack(0, 5, 0, 6, 0, 7));

    // Every hour/minute pair with a varying second, every cycle.
    for (int h = 0; h < 24; h++)
      for (int m = 0; m < 60; m++)
        step_check($sformatf("sweep_%0d_%0d", h, m), h, m, (h * 7 + m) % 60,
                   model(h, m, (h * 7 + m) % 60));

    // Full 6-bit code space on every field, including illegal codes.
    for (int v = 0; v < 64; v++)
      step_check($sformatf("code_%0d", v), v, 63 - v, v, model(v, 63 - v, v));

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 2000; i++) begin
      int h, m, s;
      logic r;
      h = int'($urandom_range(0, 63));
      m = int'($urandom_range(0, 63));
      s = int'($urandom_range(0, 63));
      r = ($urandom_range(0, 15) == 0);
      reset = r;
      step_check($sformatf("rand_%0d", i), h, m, s, r ? 36'd0 : model(h, m, s));
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
